prog_load_ctrl: RTL and testbench
=================================

Name: prog_load_ctrl

Overview:
- Sequences ownership of the instruction and data memories between the CPU and a UART program-load path.
- On a start request it holds the CPU in reset, then takes bytes from the UART receiver and assembles them into 32-bit words.
- It writes the words into instruction memory, then into data memory, and releases the CPU when the load completes.
- Sits beside the CPU top, between the UART receiver and the memory write ports; the memories mux their write port on cpu_hold.

Parameters:
- IMEM_WORDS, 16384: instruction memory depth in words.
- DMEM_WORDS, 16384: data memory depth in words.
- ADDR_W, 14: word-address width, clog2 of the larger depth.
- TIMEOUT_CYC, 2500000: idle clocks allowed between bytes (100 ms at 25 MHz).

Ports:
- clock  in  1  system clock (CPU clock domain).
- rst  in  1  asynchronous, active-low reset.
- start_load  in  1  one-cycle pulse, already synchronised/debounced externally.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- cpu_hold  out  1  1 = CPU held in reset and memory write ports owned by this block.
- imem_we  out  1  instruction memory write strobe, one cycle.
- dmem_we  out  1  data memory write strobe, one cycle.
- mem_addr  out  ADDR_W  word address for the active strobe.
- mem_wdata  out  32  assembled word.
- load_busy  out  1  a load is in progress.
- load_done  out  1  sticky: last load succeeded.
- load_err  out  1  sticky: last load failed.

Behaviour:
- Stream format, all fields little-endian 32-bit:
  - N_I, then N_I instruction words.
  - N_D, then N_D data words.
- Word assembly: mem_wdata = {b3,b2,b1,b0}, where b0 is the first byte received. A 2-bit byte index counts bytes.
- States: RUN, HDR_I, LOAD_I, HDR_D, LOAD_D, DONE, ERR.
- Reset values:
  - State RUN.
  - cpu_hold, imem_we, dmem_we, load_busy, load_done, load_err all 0.
  - mem_addr 0, mem_wdata 0, all counters 0.
- RUN:
  - rx_valid is ignored.
  - start_load -> HDR_I; cpu_hold=1, load_busy=1, load_done=0, load_err=0, byte index, word counter and timer cleared.
- HDR_I: on the 4th byte, latch N_I, then:
  - N_I > IMEM_WORDS (full 32-bit compare) -> ERR.
  - N_I = 0 -> HDR_D.
  - otherwise -> LOAD_I.
- LOAD_I:
  - Each 4th byte: imem_we=1 for exactly one cycle, in the cycle after that byte's rx_valid (registered); mem_addr = word counter, which then increments.
  - After word N_I-1 is written -> HDR_D, word counter cleared.
- HDR_D: same as HDR_I using N_D and DMEM_WORDS:
  - N_D > DMEM_WORDS -> ERR.
  - N_D = 0 -> DONE.
  - otherwise -> LOAD_D.
- LOAD_D: as LOAD_I with dmem_we. After word N_D-1 -> DONE.
- DONE: lasts one cycle; load_done=1, load_busy=0. Next cycle -> RUN with cpu_hold=0, so the CPU restarts at PC 0.
- ERR:
  - load_err=1, load_busy=0, cpu_hold stays 1; rx bytes are ignored.
  - Only start_load (retry) or reset leaves ERR.
- Timeout:
  - In HDR_I/LOAD_I/HDR_D/LOAD_D a down-counter reloads TIMEOUT_CYC on entry and on every rx_valid.
  - Reaching 0 -> ERR.
- Simultaneous events:
  - start_load with rx_valid in any load state: restart at HDR_I and discard the byte.
  - start_load in DONE: treated as a new load (HDR_I).
  - imem_we and dmem_we are never both 1.
- Reset mid-load: immediate return to RUN with cpu_hold=0. Partially written memory contents are accepted.
- Throughput: one byte per cycle is sustained; back-to-back rx_valid must not drop bytes.

Decomposition:
- Shared package/definitions file holds:
  - State encodings (3-bit localparams).
  - Byte-order constant.
  - Default depths and TIMEOUT_CYC.
- One natural sub-module: word_assembler.
  - Contains the byte index, the shift register, and a word_valid pulse on the 4th byte.
  - Cleared by a sync clear input.
- The FSM, counters and strobes stay in prog_load_ctrl.

Test Plan:
- Basic load: reset, start_load, stream N_I=2 {0x20080005, 0x8C090000}, N_D=1 {0xDEADBEEF} -> imem_we at addr 0 and 1 with those words, dmem_we at addr 0 with 0xDEADBEEF. Then DONE, load_done=1, cpu_hold falls one cycle later.
- Empty sections: N_I=0, N_D=0 -> no write strobes; DONE reached 8 bytes after start; load_err=0.
- Oversize header: N_I=0x00004001 with IMEM_WORDS=16384 -> ERR after the 4th header byte; cpu_hold=1, load_err=1, no imem_we.
- Timeout: TIMEOUT_CYC=100, send 6 bytes then stop -> ERR at the 100th idle cycle. A later start_load plus a full valid stream -> load_done=1, load_err=0.
- Restart collision: start_load coincident with the 3rd data byte of word 1 -> returns to HDR_I with the byte discarded. The new stream is written from addr 0 and no stale partial word appears.
- Async reset: drop rst while in LOAD_D with rx_valid active -> all outputs 0 immediately, state RUN, rx_valid ignored afterwards.

Source files
------------

// File: rtl/prog_load_ctrl_pkg.sv
// Shared definitions for the UART program loader: state encodings, byte order and default sizing.
package prog_load_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_HDR_I  = 3'd1,
    ST_LOAD_I = 3'd2,
    ST_HDR_D  = 3'd3,
    ST_LOAD_D = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // Stream words arrive least-significant byte first.
  localparam bit BYTE_ORDER_LE = 1'b1;

  localparam int unsigned DEF_IMEM_WORDS  = 16384;
  localparam int unsigned DEF_DMEM_WORDS  = 16384;
  localparam int unsigned DEF_ADDR_W      = 14;
  localparam int unsigned DEF_TIMEOUT_CYC = 2500000;

  function automatic logic is_load_state(input state_t s);
    return s inside {ST_HDR_I, ST_LOAD_I, ST_HDR_D, ST_LOAD_D};
  endfunction

endpackage

// File: rtl/prog_load_ctrl_word_assembler.sv
// Packs a byte stream into 32-bit words; word_vld_o is combinational on the 4th byte.
// No backpressure: one byte per cycle is accepted, clr_i wins over an incoming byte.
module prog_load_ctrl_word_assembler
  import prog_load_ctrl_pkg::*;
#(
  parameter bit LSB_FIRST = BYTE_ORDER_LE
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic        word_vld_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] shifted;

  always_comb begin
    shifted = LSB_FIRST ? {byte_i, shreg_q[31:8]} : {shreg_q[23:0], byte_i};
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if (clr_i) begin
      idx_d   = 2'd0;
      shreg_d = 32'd0;
    end else if (byte_vld_i) begin
      idx_d   = idx_q + 2'd1;
      shreg_d = shifted;
    end
  end

  assign word_vld_o = byte_vld_i && !clr_i && (idx_q == 2'd3);
  assign word_o     = shifted;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      idx_q   <= 2'd0;
      shreg_q <= 32'd0;
    end else begin
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/prog_load_ctrl.sv
// Holds the CPU in reset while a UART byte stream (N_I, imem words, N_D, dmem words) is written to memory.
// Write strobes are registered one cycle after the completing byte; a byte per cycle is sustained.
module prog_load_ctrl
  import prog_load_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_WORDS  = DEF_IMEM_WORDS,
  parameter int unsigned DMEM_WORDS  = DEF_DMEM_WORDS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start_load,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              cpu_hold,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [31:0]   TMO     = 32'(TIMEOUT_CYC);
  localparam logic [31:0]   IMEM_LIM = 32'(IMEM_WORDS);
  localparam logic [31:0]   DMEM_LIM = 32'(DMEM_WORDS);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   cnt_inc;
  logic [31:0]       timer_q, timer_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              imem_we_q, imem_we_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              loading;
  logic              word_vld;
  logic [31:0]       word;
  logic              to_err;
  logic              to_done;

  assign loading = is_load_state(state_q);
  assign cnt_inc = cnt_q + CNT_ONE;

  // Bytes only count while loading; a start pulse flushes any partial word.
  prog_load_ctrl_word_assembler u_asm (
    .clock      (clock),
    .rst        (rst),
    .clr_i      (start_load),
    .byte_vld_i (rx_valid && loading),
    .byte_i     (rx_data),
    .word_vld_o (word_vld),
    .word_o     (word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    timer_d    = timer_q;
    cpu_hold_d = cpu_hold_q;
    imem_we_d  = 1'b0;
    dmem_we_d  = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    to_err     = 1'b0;
    to_done    = 1'b0;

    if (start_load) begin
      state_d    = ST_HDR_I;
      cpu_hold_d = 1'b1;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      err_d      = 1'b0;
      cnt_d      = '0;
      timer_d    = TMO;
    end else if (loading) begin
      if (rx_valid) begin
        timer_d = TMO;
      end else if (timer_q <= 32'd1) begin
        to_err = 1'b1;
      end else begin
        timer_d = timer_q - 32'd1;
      end

      if (word_vld) begin
        case (state_q)
          ST_HDR_I: begin
            cnt_d = '0;
            if (word > IMEM_LIM) begin
              to_err = 1'b1;
            end else if (word == 32'd0) begin
              state_d = ST_HDR_D;
            end else begin
              n_d     = word[ADDR_W:0];
              state_d = ST_LOAD_I;
            end
          end
          ST_LOAD_I: begin
            imem_we_d = 1'b1;
            addr_d    = cnt_q[ADDR_W-1:0];
            wdata_d   = word;
            if (cnt_inc == n_q) begin
              cnt_d   = '0;
              state_d = ST_HDR_D;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          ST_HDR_D: begin
            cnt_d = '0;
            if (word > DMEM_LIM) begin
              to_err = 1'b1;
            end else if (word == 32'd0) begin
              to_done = 1'b1;
            end else begin
              n_d     = word[ADDR_W:0];
              state_d = ST_LOAD_D;
            end
          end
          ST_LOAD_D: begin
            dmem_we_d = 1'b1;
            addr_d    = cnt_q[ADDR_W-1:0];
            wdata_d   = word;
            if (cnt_inc == n_q) begin
              cnt_d   = '0;
              to_done = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          default: ;
        endcase
      end
    end else if (state_q == ST_DONE) begin
      // CPU leaves reset one cycle after DONE, starting from PC 0.
      state_d    = ST_RUN;
      cpu_hold_d = 1'b0;
    end

    if (to_err) begin
      state_d = ST_ERR;
      busy_d  = 1'b0;
      err_d   = 1'b1;
    end else if (to_done) begin
      state_d = ST_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      n_q        <= '0;
      timer_q    <= 32'd0;
      cpu_hold_q <= 1'b0;
      imem_we_q  <= 1'b0;
      dmem_we_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      timer_q    <= timer_d;
      cpu_hold_q <= cpu_hold_d;
      imem_we_q  <= imem_we_d;
      dmem_we_q  <= dmem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cpu_hold  = cpu_hold_q;
  assign imem_we   = imem_we_q;
  assign dmem_we   = dmem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign load_busy = busy_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl with a stream-level reference model checked every cycle.
module tb_prog_load_ctrl;

  localparam int TMO  = 100;
  localparam int IMEM = 16384;
  localparam int DMEM = 16384;
  localparam int AW   = 14;

  localparam int P_RUN  = 0;
  localparam int P_HI   = 1;
  localparam int P_LI   = 2;
  localparam int P_HD   = 3;
  localparam int P_LD   = 4;
  localparam int P_DONE = 5;
  localparam int P_ERR  = 6;

  logic          clock = 1'b0;
  logic          rst = 1'b0;
  logic          start_load = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          cpu_hold, imem_we, dmem_we, load_busy, load_done, load_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  prog_load_ctrl #(
    .IMEM_WORDS (IMEM),
    .DMEM_WORDS (DMEM),
    .ADDR_W     (AW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .start_load(start_load),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .cpu_hold  (cpu_hold),
    .imem_we   (imem_we),
    .dmem_we   (dmem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .load_busy (load_busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, wanted %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the stream section and byte collection, not the RTL's registers.
  int           m_ph;
  logic [7:0]   m_bytes[$];
  int           m_cnt, m_n, m_idle;
  logic         e_hold, e_iwe, e_dwe, e_busy, e_done, e_err;
  logic [AW-1:0] e_addr;
  logic [31:0]  e_wdata;
  int           m_wr_sec[$];
  int           m_wr_addr[$];
  logic [31:0]  m_wr_data[$];

  task automatic model_reset();
    m_ph = P_RUN; m_bytes.delete(); m_cnt = 0; m_n = 0; m_idle = 0;
    e_hold = 0; e_iwe = 0; e_dwe = 0; e_busy = 0; e_done = 0; e_err = 0;
    e_addr = '0; e_wdata = '0;
  endtask

  task automatic model_err();
    m_ph = P_ERR; e_busy = 0; e_err = 1;
  endtask

  task automatic model_done();
    m_ph = P_DONE; e_busy = 0; e_done = 1;
  endtask

  task automatic model_word(input logic [31:0] w);
    longint wl;
    wl = longint'(w);
    case (m_ph)
      P_HI: begin
        if (wl > IMEM) model_err();
        else if (wl == 0) m_ph = P_HD;
        else begin m_n = int'(wl); m_cnt = 0; m_ph = P_LI; end
      end
      P_HD: begin
        if (wl > DMEM) model_err();
        else if (wl == 0) model_done();
        else begin m_n = int'(wl); m_cnt = 0; m_ph = P_LD; end
      end
      P_LI, P_LD: begin
        if (m_ph == P_LI) e_iwe = 1; else e_dwe = 1;
        e_addr  = AW'(m_cnt);
        e_wdata = w;
        m_wr_sec.push_back(m_ph == P_LI ? 0 : 1);
        m_wr_addr.push_back(m_cnt);
        m_wr_data.push_back(w);
        m_cnt++;
        if (m_cnt == m_n) begin
          m_cnt = 0;
          if (m_ph == P_LI) m_ph = P_HD; else model_done();
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_step(input logic sl, input logic rv, input logic [7:0] rd);
    logic [31:0] w;
    e_iwe = 0; e_dwe = 0;
    if (sl) begin
      m_ph = P_HI; m_bytes.delete(); m_cnt = 0; m_idle = 0;
      e_hold = 1; e_busy = 1; e_done = 0; e_err = 0;
    end else if (m_ph >= P_HI && m_ph <= P_LD) begin
      if (rv) begin
        m_idle = 0;
        m_bytes.push_back(rd);
        if (m_bytes.size() == 4) begin
          w = 32'(m_bytes[0]) + (32'(m_bytes[1]) << 8) + (32'(m_bytes[2]) << 16) + (32'(m_bytes[3]) << 24);
          m_bytes.delete();
          model_word(w);
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) model_err();
      end
    end else if (m_ph == P_DONE) begin
      m_ph = P_RUN; e_hold = 0;
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {12'd0, cpu_hold, imem_we, dmem_we, load_busy, load_done, load_err, mem_addr, mem_wdata};
  endfunction

  function automatic logic [63:0] exp_vec();
    return {12'd0, e_hold, e_iwe, e_dwe, e_busy, e_done, e_err, e_addr, e_wdata};
  endfunction

  // Outputs settle after posedge; inputs change at posedge+1, so at negedge they are what the next edge samples.
  always @(negedge clock) begin
    if (!rst) model_reset();
    check("cycle_outputs", dut_vec(), exp_vec());
    if (rst) model_step(start_load, rx_valid, rx_data);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[7:0]);
      t = t >> 8;
    end
  endtask

  task automatic check_wr(input string name, input int idx, input int sec, input int addr, input logic [31:0] data);
    logic [63:0] act;
    if (idx < m_wr_data.size()) act = {8'(m_wr_sec[idx]), 24'(m_wr_addr[idx]), m_wr_data[idx]};
    else act = '1;
    check(name, act, {8'(sec), 24'(addr), data});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) tick();
    check("reset_outputs", dut_vec(), 64'd0);
    rst = 1'b1;
    repeat (2) tick();

    // Basic load
    base = m_wr_data.size();
    pulse_start();
    send_word(32'd2);
    send_word(32'h20080005);
    send_word(32'h8C090000);
    send_word(32'd1);
    send_word(32'hDEADBEEF);
    check("t1_done_flag", 64'(load_done), 64'd1);
    check("t1_hold_in_done", 64'(cpu_hold), 64'd1);
    check("t1_dmem_we", 64'(dmem_we), 64'd1);
    check("t1_dmem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    check("t1_wr_count", 64'(m_wr_data.size() - base), 64'd3);
    check_wr("t1_wr0", base + 0, 0, 0, 32'h20080005);
    check_wr("t1_wr1", base + 1, 0, 1, 32'h8C090000);
    check_wr("t1_wr2", base + 2, 1, 0, 32'hDEADBEEF);
    tick();
    check("t1_hold_released", 64'(cpu_hold), 64'd0);
    check("t1_done_sticky", 64'(load_done), 64'd1);
    repeat (3) tick();

    // Empty sections: DONE on the 8th byte
    base = m_wr_data.size();
    pulse_start();
    send_word(32'd0);
    send_byte(8'd0); send_byte(8'd0); send_byte(8'd0);
    check("t2_not_done_at_7", 64'(load_done), 64'd0);
    send_byte(8'd0);
    check("t2_done_at_8", 64'(load_done), 64'd1);
    check("t2_no_err", 64'(load_err), 64'd0);
    check("t2_no_writes", 64'(m_wr_data.size() - base), 64'd0);
    repeat (3) tick();

    // Oversize instruction header
    base = m_wr_data.size();
    pulse_start();
    send_byte(8'h01); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
    check("t3_err", 64'(load_err), 64'd1);
    check("t3_hold", 64'(cpu_hold), 64'd1);
    check("t3_busy", 64'(load_busy), 64'd0);
    send_word(32'h12345678);
    repeat (20) tick();
    check("t3_err_sticky", 64'(load_err), 64'd1);
    check("t3_no_writes", 64'(m_wr_data.size() - base), 64'd0);

    // Timeout after 6 bytes, then a clean retry
    base = m_wr_data.size();
    pulse_start();
    check("t4_retry_clears_err", 64'({load_busy, load_err}), 64'b10);
    send_word(32'd1);
    send_byte(8'h11); send_byte(8'h22);
    repeat (TMO - 1) tick();
    check("t4_no_err_before_limit", 64'(load_err), 64'd0);
    tick();
    check("t4_timeout_err", 64'(load_err), 64'd1);
    check("t4_hold_kept", 64'(cpu_hold), 64'd1);
    pulse_start();
    send_word(32'd1);
    send_word(32'h11223344);
    send_word(32'd2);
    send_word(32'hA5A5A5A5);
    send_word(32'h00000007);
    check("t4_done", 64'({load_done, load_err}), 64'b10);
    check("t4_wr_count", 64'(m_wr_data.size() - base), 64'd3);
    check_wr("t4_wr0", base + 0, 0, 0, 32'h11223344);
    check_wr("t4_wr1", base + 1, 1, 0, 32'hA5A5A5A5);
    check_wr("t4_wr2", base + 2, 1, 1, 32'h00000007);
    repeat (3) tick();

    // Restart colliding with the 3rd byte of instruction word 1
    base = m_wr_data.size();
    pulse_start();
    send_word(32'd3);
    send_word(32'hCAFEF00D);
    send_byte(8'hEE); send_byte(8'hDD);
    start_load = 1'b1; rx_valid = 1'b1; rx_data = 8'hCC;
    tick();
    start_load = 1'b0; rx_valid = 1'b0;
    check("t5_busy_after_restart", 64'(load_busy), 64'd1);
    send_word(32'd1);
    send_word(32'h01020304);
    send_word(32'd0);
    check("t5_done", 64'({load_done, load_err}), 64'b10);
    check("t5_wr_count", 64'(m_wr_data.size() - base), 64'd2);
    check_wr("t5_wr0", base + 0, 0, 0, 32'hCAFEF00D);
    check_wr("t5_wr1", base + 1, 0, 0, 32'h01020304);
    repeat (3) tick();

    // Asynchronous reset during LOAD_D with bytes streaming
    base = m_wr_data.size();
    pulse_start();
    send_word(32'd0);
    send_word(32'd2);
    send_word(32'h55667788);
    rx_valid = 1'b1; rx_data = 8'h99;
    tick();
    rx_data = 8'hAA;
    #2 rst = 1'b0;
    #1;
    check("t6_async_reset", dut_vec(), 64'd0);
    repeat (2) begin rx_data = rx_data + 8'h01; tick(); end
    rst = 1'b1;
    repeat (6) begin rx_data = rx_data + 8'h11; tick(); end
    rx_valid = 1'b0;
    check("t6_ignored_after_reset", 64'({cpu_hold, load_busy, load_done, dmem_we}), 64'd0);
    check("t6_wr_count", 64'(m_wr_data.size() - base), 64'd1);
    check_wr("t6_wr0", base + 0, 1, 0, 32'h55667788);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
